// File: rtl/esn_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : esn_reset_sequencer_if
// Brief    : Lock/request inputs and reset/status outputs of the ESN reset
//            sequencer, bundled for the top-level wrapper.
// Revision : 1.0 - initial release
// ============================================================================
interface esn_reset_sequencer_if;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       sys_rst_n;
  logic       esn_rst_n;
  logic       ready;
  logic [2:0] state;
  logic [7:0] lock_loss_count;

  // Wrapper / PLL side: supplies lock and software requests, observes status
  modport master (
    output pll_locked,
    output sw_reset_req,
    input  sys_rst_n,
    input  esn_rst_n,
    input  ready,
    input  state,
    input  lock_loss_count
  );

  // Sequencer side
  modport slave (
    input  pll_locked,
    input  sw_reset_req,
    output sys_rst_n,
    output esn_rst_n,
    output ready,
    output state,
    output lock_loss_count
  );
endinterface
`default_nettype wire

// File: rtl/esn_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : esn_reset_sequencer
// Brief    : Qualifies the PLL lock, then releases the system reset followed
//            by the ESN reset. Re-asserts both on lock loss and serves
//            software-requested ESN-only reset pulses.
// Revision : 1.0 - initial release
// ============================================================================
module esn_reset_sequencer #(
  parameter int STABLE_CYCLES     = 1024,
  parameter int SYS_TO_ESN_CYCLES = 16,
  parameter int SW_RESET_CYCLES   = 8,
  parameter int CNT_W             = 16
) (
  input  wire                      clock_50,
  input  wire                      reset_n,
  esn_reset_sequencer_if.slave     bus
);

  localparam logic [2:0] c_WAIT_LOCK   = 3'd0;
  localparam logic [2:0] c_STABLE      = 3'd1;
  localparam logic [2:0] c_RELEASE_SYS = 3'd2;
  localparam logic [2:0] c_RUN         = 3'd3;
  localparam logic [2:0] c_SW_RESET    = 3'd4;

  localparam logic [CNT_W-1:0] c_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_SYS_LAST    = CNT_W'(SYS_TO_ESN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_SW_LAST     = CNT_W'(SW_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       llc_q, llc_d;
  logic             sys_rst_n_q, esn_rst_n_q, ready_q;
  logic             locked_s;
  logic [7:0]       llc_inc;

  assign locked_s = sync2_q;
  // Saturating increment: a long flapping PLL must not wrap the count to 0
  assign llc_inc  = (llc_q == 8'hFF) ? llc_q : llc_q + 8'd1;

  // Two-flop synchroniser for the asynchronous lock indication
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counter and lock-loss bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    llc_d   = llc_q;
    case (state_q)
      c_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = c_STABLE;
          cnt_d   = '0;
        end
      end
      c_STABLE: begin
        // Resets were never released here, so a drop is not a lock loss
        if (!locked_s) begin
          state_d = c_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == c_STABLE_LAST) begin
          state_d = c_RELEASE_SYS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      c_RELEASE_SYS: begin
        if (!locked_s) begin
          state_d = c_WAIT_LOCK;
          cnt_d   = '0;
          llc_d   = llc_inc;
        end else if (cnt_q == c_SYS_LAST) begin
          state_d = c_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      c_RUN: begin
        // Lock loss outranks a simultaneous software request
        if (!locked_s) begin
          state_d = c_WAIT_LOCK;
          cnt_d   = '0;
          llc_d   = llc_inc;
        end else if (bus.sw_reset_req) begin
          state_d = c_SW_RESET;
          cnt_d   = '0;
        end
      end
      c_SW_RESET: begin
        // Requests arriving here are dropped, not queued
        if (!locked_s) begin
          state_d = c_WAIT_LOCK;
          cnt_d   = '0;
          llc_d   = llc_inc;
        end else if (cnt_q == c_SW_LAST) begin
          state_d = c_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      default: begin
        state_d = c_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; outputs decode the next state so they move with it
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      state_q     <= c_WAIT_LOCK;
      cnt_q       <= '0;
      llc_q       <= 8'd0;
      sys_rst_n_q <= 1'b0;
      esn_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      llc_q       <= llc_d;
      sys_rst_n_q <= (state_d == c_RELEASE_SYS) || (state_d == c_RUN) ||
                     (state_d == c_SW_RESET);
      esn_rst_n_q <= (state_d == c_RUN);
      ready_q     <= (state_d == c_RUN);
    end
  end

  assign bus.sys_rst_n       = sys_rst_n_q;
  assign bus.esn_rst_n       = esn_rst_n_q;
  assign bus.ready           = ready_q;
  assign bus.state           = state_q;
  assign bus.lock_loss_count = llc_q;

endmodule
`default_nettype wire
